// File: rtl/burst_master.sv
// Single-burst bus master: takes one read/write command, runs the AR/R or AW/W/B
// handshakes against the slave, and reports completion with a 2-bit status.
//   state  | meaning
//   S_IDLE | waiting for a command, cmd_ready high
//   S_AR   | read address offered
//   S_R    | collecting read beats
//   S_AW   | write address offered
//   S_W    | streaming write bytes straight through to the bus
//   S_B    | waiting for write response
//   S_DONE | one-cycle completion pulse with status
module burst_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          ID_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_id,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_err,
    output logic        done,
    output logic [1:0]  status,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [15:0] IN,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic        RLAST,
    input  logic [8:0]  OUT,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [11:0] AWIN,
    output logic        WVALID,
    input  logic        WREADY,
    output logic        WLAST,
    output logic [7:0]  WDATA,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [4:0]  BRESP
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  addr_q;
    logic [3:0]  len_q, id_q;
    logic [3:0]  beat, beat_n, beat_inc;
    logic [15:0] tcnt, tcnt_n;
    logic        slv_err, slv_n, prot_err, prot_n, tmo, tmo_n;
    logic        latch, tick, in_w, w_last;
    logic [1:0]  status_n;

    assign in_w   = (state == S_W);
    assign w_last = (beat == len_q - 4'd1);

    always_comb begin
        state_n  = state;
        beat_n   = beat;
        beat_inc = beat + 4'd1;
        tcnt_n   = tcnt;
        slv_n    = slv_err;
        prot_n   = prot_err;
        tmo_n    = tmo;
        latch    = 1'b0;
        tick     = 1'b0;
        unique case (state)
            S_IDLE: if (cmd_valid) begin
                latch  = 1'b1;
                beat_n = '0;
                tcnt_n = '0;
                slv_n  = 1'b0;
                prot_n = 1'b0;
                tmo_n  = 1'b0;
                if (cmd_len == 4'd0) begin
                    prot_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    state_n = cmd_write ? S_AW : S_AR;
                end
            end
            S_AR: if (ARREADY) begin
                state_n = S_R;
                tcnt_n  = '0;
            end else tick = 1'b1;
            S_R: if (RVALID) begin
                beat_n = beat_inc;
                tcnt_n = '0;
                if (OUT[0]) slv_n = 1'b1;
                // Either end marker closes the burst; they must coincide.
                if (RLAST || beat_inc == len_q) begin
                    state_n = S_DONE;
                    if (!(RLAST && beat_inc == len_q)) prot_n = 1'b1;
                end
            end else tick = 1'b1;
            S_AW: if (AWREADY) begin
                state_n = S_W;
                tcnt_n  = '0;
            end else tick = 1'b1;
            S_W: if (wr_valid && WREADY) begin
                beat_n = beat_inc;
                tcnt_n = '0;
                if (w_last) state_n = S_B;
            end else tick = 1'b1;
            S_B: if (BVALID) begin
                if (BRESP[4]) slv_n = 1'b1;
                if (ID_CHECK && BRESP[3:0] != id_q) prot_n = 1'b1;
                state_n = S_DONE;
            end else tick = 1'b1;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (tick) begin
            if (TIMEOUT != 0 && 32'(tcnt) == TIMEOUT - 1) begin
                tmo_n   = 1'b1;
                state_n = S_DONE;
            end else begin
                tcnt_n = tcnt + 16'd1;
            end
        end
        status_n = tmo_n ? 2'b11 : prot_n ? 2'b10 : slv_n ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat     <= '0;
            tcnt     <= '0;
            slv_err  <= 1'b0;
            prot_err <= 1'b0;
            tmo      <= 1'b0;
            status   <= 2'b00;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_n;
            beat     <= beat_n;
            tcnt     <= tcnt_n;
            slv_err  <= slv_n;
            prot_err <= prot_n;
            tmo      <= tmo_n;
            if (latch) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                id_q   <= cmd_id;
            end
            if (state_n == S_DONE) status <= status_n;
            rd_valid <= (state == S_R) && RVALID;
            if ((state == S_R) && RVALID) begin
                rd_data <= OUT[8:1];
                rd_err  <= OUT[0];
            end
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign ARVALID   = (state == S_AR);
    assign RREADY    = (state == S_R);
    assign AWVALID   = (state == S_AW);
    assign BREADY    = (state == S_B);
    assign done      = (state == S_DONE);
    assign IN        = {addr_q, len_q, id_q};
    assign AWIN      = {addr_q, id_q};
    // Write data path is a combinational pass-through while in S_W.
    assign WVALID    = in_w & wr_valid;
    assign WDATA     = in_w ? wr_data : 8'h00;
    assign WLAST     = in_w & w_last;
    assign wr_ready  = in_w & WREADY;

endmodule

// File: tb/tb_burst_master.sv
// Directed bench for burst_master: bench-side slave memory, expected-status and
// expected-beat scoreboards, and literal checks that pin the model.
module tb_burst_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 0, cmd_write = 0;
    logic [7:0]  cmd_addr = 0;
    logic [3:0]  cmd_len = 0, cmd_id = 0;
    logic        wr_valid = 0;
    logic [7:0]  wr_data = 0;
    logic        cmd_ready, wr_ready, rd_valid, rd_err, done;
    logic [7:0]  rd_data;
    logic [1:0]  status;
    logic        ARVALID, ARREADY = 0;
    logic [15:0] IN;
    logic        RVALID = 0, RREADY, RLAST = 0;
    logic [8:0]  OUT = 0;
    logic        AWVALID, AWREADY = 0;
    logic [11:0] AWIN;
    logic        WVALID, WREADY = 0, WLAST;
    logic [7:0]  WDATA;
    logic        BVALID = 0, BREADY;
    logic [4:0]  BRESP = 0;

    burst_master #(.TIMEOUT(8), .ID_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .done(done), .status(status),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .IN(IN), .RVALID(RVALID), .RREADY(RREADY),
        .RLAST(RLAST), .OUT(OUT), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWIN(AWIN),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [7:0] mem [256];
    logic [8:0] exp_rd_q [$];
    logic [1:0] exp_st_q [$];
    logic [8:0] cap [$];
    logic [7:0] wdat [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    // Scoreboard: every read beat and every done pulse must have been predicted.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    chk("rd_beat", {rd_data, rd_err}, exp_rd_q.pop_front());
                    cap.push_back({rd_data, rd_err});
                end
            end
            if (done) begin
                if (exp_st_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("status", status, exp_st_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            nclk();
            if (cmd_ready) begin ok = 1; break; end
        end
        chk({nm, "_back_to_idle"}, ok, 1);
        chk({nm, "_all_predicted_seen"}, exp_st_q.size() + exp_rd_q.size(), 0);
    endtask

    task automatic issue_cmd(input logic wr, input logic [7:0] a, input logic [3:0] l, input logic [3:0] id);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
        nclk();
        cmd_valid = 0;
        chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic do_write(input string nm, input logic [7:0] a, input logic [3:0] l,
                            input logic [3:0] id, input logic [4:0] br);
        logic [1:0] st;
        st = (br[3:0] != id) ? 2'b10 : br[4] ? 2'b01 : 2'b00;
        exp_st_q.push_back(st);
        issue_cmd(1, a, l, id);
        chk({nm, "_awvalid"}, AWVALID, 1);
        chk({nm, "_awin"}, AWIN, {a, id});
        AWREADY = 1; nclk(); AWREADY = 0;
        for (int i = 0; i < int'(l); i++) begin
            wr_valid = 1; wr_data = wdat[i]; WREADY = 1;
            #1;
            chk({nm, "_wlast"}, WLAST, (i == int'(l) - 1));
            chk({nm, "_wdata"}, {WVALID, wr_ready, WDATA}, {2'b11, wdat[i]});
            mem[a + 8'(i)] = wdat[i];
            nclk();
        end
        wr_valid = 0; WREADY = 0;
        chk({nm, "_bready"}, BREADY, 1);
        BVALID = 1; BRESP = br; nclk(); BVALID = 0; BRESP = 0;
        wait_idle(nm);
    endtask

    // Slave returns mem data; addresses past 0xFF are reported as error beats.
    task automatic do_read(input string nm, input logic [7:0] a, input logic [3:0] l,
                           input logic [3:0] id, input int rlast_pos);
        int nb, ad;
        bit slv, prot;
        logic [8:0] beats [16];
        nb = (rlast_pos + 1 < int'(l)) ? rlast_pos + 1 : int'(l);
        slv = 0;
        prot = (rlast_pos + 1 != int'(l));
        for (int i = 0; i < nb; i++) begin
            ad = int'(a) + i;
            beats[i] = (ad > 255) ? 9'h001 : {mem[ad], 1'b0};
            if (ad > 255) slv = 1;
            exp_rd_q.push_back(beats[i]);
        end
        exp_st_q.push_back(prot ? 2'b10 : slv ? 2'b01 : 2'b00);
        cap.delete();
        issue_cmd(0, a, l, id);
        chk({nm, "_arvalid"}, ARVALID, 1);
        chk({nm, "_in"}, IN, {a, l, id});
        ARREADY = 1; nclk(); ARREADY = 0;
        chk({nm, "_rready"}, RREADY, 1);
        for (int i = 0; i < nb; i++) begin
            RVALID = 1; OUT = beats[i]; RLAST = (i == rlast_pos);
            nclk();
        end
        RVALID = 0; RLAST = 0; OUT = 0;
        wait_idle(nm);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) nclk();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {ARVALID, AWVALID, RREADY, BREADY, WVALID, wr_ready, WLAST}, 0);
        chk("rst_done_rd", {done, rd_valid, rd_err, status}, 0);
        chk("rst_fields", {IN, AWIN, rd_data}, 0);
        rst = 0;
        nclk();

        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
        do_write("wr4", 8'h10, 4'd4, 4'd3, 5'h03);

        do_read("rd4", 8'h10, 4'd4, 4'd3, 3);
        chk("rd4_lit_n", cap.size(), 4);
        if (cap.size() == 4) begin
            chk("rd4_lit0", cap[0], {8'h11, 1'b0});
            chk("rd4_lit1", cap[1], {8'h22, 1'b0});
            chk("rd4_lit2", cap[2], {8'h33, 1'b0});
            chk("rd4_lit3", cap[3], {8'h44, 1'b0});
        end

        do_read("rd_edge", 8'hFE, 4'd3, 4'd1, 2);
        chk("rd_edge_lit_n", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("rd_edge_lit_err0", cap[0][0], 0);
            chk("rd_edge_lit_beat3", cap[2], 9'h001);
        end

        // AR never accepted: ARVALID must stay high for exactly 8 cycles.
        exp_st_q.push_back(2'b11);
        issue_cmd(0, 8'h30, 4'd2, 4'd4);
        cnt = 0;
        for (int k = 0; k < 40 && ARVALID; k++) begin cnt++; nclk(); end
        chk("ar_timeout_cycles", cnt, 8);
        chk("ar_timeout_done", done, 1);
        wait_idle("ar_timeout");

        // Zero-length command: no bus activity, done the next cycle.
        exp_st_q.push_back(2'b10);
        issue_cmd(1, 8'h20, 4'd0, 4'd5);
        chk("len0_no_bus", {ARVALID, AWVALID}, 0);
        chk("len0_done", done, 1);
        wait_idle("len0");

        wdat[0] = 8'hA5;
        do_write("wr_badid", 8'h40, 4'd1, 4'd7, 5'h06);
        wdat[0] = 8'h5A; wdat[1] = 8'hC3;
        do_write("wr_slverr", 8'h41, 4'd2, 4'd2, 5'h12);
        do_write("wr_both", 8'h41, 4'd2, 4'd2, 5'h13);
        for (int i = 0; i < 15; i++) wdat[i] = 8'(i * 3 + 1);
        do_write("wr15", 8'h50, 4'd15, 4'd1, 5'h01);
        do_read("rd15", 8'h50, 4'd15, 4'd1, 14);
        chk("rd15_lit_last", cap.size() == 15 ? cap[14] : 9'h1FF, {8'd43, 1'b0});

        do_read("rd_early_last", 8'h10, 4'd3, 4'd6, 1);
        do_read("rd_no_last", 8'h12, 4'd2, 4'd6, 15);

        // Write stalls with no data offered: timeout in the data phase.
        exp_st_q.push_back(2'b11);
        issue_cmd(1, 8'h60, 4'd2, 4'd8);
        AWREADY = 1; nclk(); AWREADY = 0;
        WREADY = 1;
        wait_idle("w_timeout");
        WREADY = 0;

        // Reset in the middle of a 5-beat write, after two beats.
        for (int i = 0; i < 5; i++) wdat[i] = 8'(8'h70 + i);
        issue_cmd(1, 8'h70, 4'd5, 4'd9);
        AWREADY = 1; nclk(); AWREADY = 0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1; wr_data = wdat[i]; WREADY = 1; nclk();
        end
        wr_data = wdat[2];
        #1;
        chk("midw_wvalid_before", WVALID, 1);
        #1 rst = 1;
        #1;
        chk("midw_rst_bus", {WVALID, wr_ready, WLAST, WDATA, AWVALID, BREADY}, 0);
        chk("midw_rst_ctl", {cmd_ready, done, status}, {1'b1, 1'b0, 2'b00});
        nclk();
        wr_valid = 0; WREADY = 0;
        rst = 0;
        repeat (3) nclk();
        chk("midw_idle_after", cmd_ready, 1);

        wdat[0] = 8'hEE; wdat[1] = 8'hDD;
        do_write("wr_after_rst", 8'h80, 4'd2, 4'd2, 5'h02);
        do_read("rd_after_rst", 8'h80, 4'd2, 4'd2, 1);
        chk("rd_after_rst_lit", cap.size() == 2 ? cap[1] : 9'h000, {8'hDD, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
